// File: rtl/lint_2_axi_mo.sv
// LINT-to-AXI4 bridge: up to MAX_OUTSTANDING in flight, responses returned in request order.
// Optional macro LINT2AXI_MO_REG_RESP_EN registers the LINT response outputs (one extra cycle).
module lint_2_axi_mo #(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH/8,
  parameter int ID_WIDTH        = 16,
  parameter int AUX_WIDTH       = 10,
  parameter int USER_WIDTH      = 10,
  parameter int AXI_ID_WIDTH    = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              data_req_i,
  input  logic [ADDR_WIDTH-1:0]             data_addr_i,
  input  logic                              data_we_i,
  input  logic [31:0]                       data_wdata_i,
  input  logic [3:0]                        data_be_i,
  input  logic [ID_WIDTH-1:0]               data_ID_i,
  input  logic [AUX_WIDTH-1:0]              data_aux_i,
  output logic                              data_gnt_o,
  output logic                              data_rvalid_o,
  output logic [31:0]                       data_rdata_o,
  output logic                              data_ropc_o,
  output logic [ID_WIDTH-1:0]               data_rID_o,
  output logic [AUX_WIDTH-1:0]              data_raux_o,
  output logic                              aw_valid_o,
  input  logic                              aw_ready_i,
  output logic [ADDR_WIDTH-1:0]             aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]           aw_id_o,
  output logic [7:0]                        aw_len_o,
  output logic [2:0]                        aw_size_o,
  output logic [1:0]                        aw_burst_o,
  output logic                              aw_lock_o,
  output logic [3:0]                        aw_cache_o,
  output logic [2:0]                        aw_prot_o,
  output logic [3:0]                        aw_region_o,
  output logic [3:0]                        aw_qos_o,
  output logic [USER_WIDTH-1:0]             aw_user_o,
  output logic                              w_valid_o,
  input  logic                              w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]         w_data_o,
  output logic [AXI_STRB_WIDTH-1:0]         w_strb_o,
  output logic                              w_last_o,
  output logic [USER_WIDTH-1:0]             w_user_o,
  input  logic                              b_valid_i,
  output logic                              b_ready_o,
  input  logic [1:0]                        b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]           b_id_i,
  input  logic [USER_WIDTH-1:0]             b_user_i,
  output logic                              ar_valid_o,
  input  logic                              ar_ready_i,
  output logic [ADDR_WIDTH-1:0]             ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]           ar_id_o,
  output logic [7:0]                        ar_len_o,
  output logic [2:0]                        ar_size_o,
  output logic [1:0]                        ar_burst_o,
  output logic                              ar_lock_o,
  output logic [3:0]                        ar_cache_o,
  output logic [2:0]                        ar_prot_o,
  output logic [3:0]                        ar_region_o,
  output logic [3:0]                        ar_qos_o,
  output logic [USER_WIDTH-1:0]             ar_user_o,
  input  logic                              r_valid_i,
  output logic                              r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]         r_data_i,
  input  logic [1:0]                        r_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]           r_id_i,
  input  logic                              r_last_i,
  input  logic [USER_WIDTH-1:0]             r_user_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o
);

  localparam int LANE = AXI_DATA_WIDTH/32;
  localparam int LW   = (LANE > 1) ? $clog2(LANE) : 1;
  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int CW   = PW + 1;
  localparam int EW   = 1 + LW + ID_WIDTH + AUX_WIDTH;
  localparam int DIW  = $clog2(AXI_DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;
  logic [LW-1:0]   req_lane;
  logic            head_we;
  logic [LW-1:0]   head_lane;
  logic [ID_WIDTH-1:0]  head_id;
  logic [AUX_WIDTH-1:0] head_aux;
  logic [DIW-1:0]  rd_sel;
  logic [AXI_STRB_WIDTH-1:0] be_ext;

  logic                 rsp_vld_d, rsp_opc_d;
  logic [31:0]          rsp_rdata_d;
  logic [ID_WIDTH-1:0]  rsp_id_d;
  logic [AUX_WIDTH-1:0] rsp_aux_d;

  generate
    if (LANE > 1) begin : g_lane
      assign req_lane = data_addr_i[$clog2(AXI_STRB_WIDTH)-1:2];
    end else begin : g_nolane
      assign req_lane = '0;
    end
  endgenerate

  // Fixed single-beat, 32-bit INCR bursts on ID 0.
  assign aw_id_o     = '0;
  assign aw_len_o    = '0;
  assign aw_size_o   = 3'b010;
  assign aw_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = '0;
  assign aw_prot_o   = '0;
  assign aw_region_o = '0;
  assign aw_qos_o    = '0;
  assign aw_user_o   = '0;
  assign ar_id_o     = '0;
  assign ar_len_o    = '0;
  assign ar_size_o   = 3'b010;
  assign ar_burst_o  = 2'b01;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = '0;
  assign ar_prot_o   = '0;
  assign ar_region_o = '0;
  assign ar_qos_o    = '0;
  assign ar_user_o   = '0;
  assign w_user_o    = '0;
  assign w_last_o    = 1'b1;

  assign aw_addr_o = data_addr_i;
  assign ar_addr_o = data_addr_i;
  assign w_data_o  = {LANE{data_wdata_i}};
  assign be_ext    = AXI_STRB_WIDTH'(data_be_i);
  assign w_strb_o  = be_ext << {req_lane, 2'b00};

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    aw_valid_o = 1'b0;
    w_valid_o  = 1'b0;
    ar_valid_o = 1'b0;
    data_gnt_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_i && !full) begin
          if (data_we_i) begin
            aw_valid_o = 1'b1;
            w_valid_o  = 1'b1;
            if (aw_ready_i && w_ready_i) data_gnt_o = 1'b1;
            else if (aw_ready_i)         state_d    = WR_DATA;
            else if (w_ready_i)          state_d    = WR_ADDR;
          end else begin
            ar_valid_o = 1'b1;
            data_gnt_o = ar_ready_i;
          end
        end
      end
      WR_ADDR: begin
        aw_valid_o = 1'b1;
        if (aw_ready_i) begin
          data_gnt_o = 1'b1;
          state_d    = IDLE;
        end
      end
      WR_DATA: begin
        w_valid_o = 1'b1;
        if (w_ready_i) begin
          data_gnt_o = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = data_gnt_o;
  assign {head_we, head_lane, head_id, head_aux} = fifo_q[rptr_q];

  // Only the channel matching the oldest transaction is drained; the other stalls.
  assign b_ready_o = !empty && head_we;
  assign r_ready_o = !empty && !head_we;
  assign pop       = (b_ready_o && b_valid_i) || (r_ready_o && r_valid_i);

  assign wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
  assign rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= {data_we_i, req_lane, data_ID_i, data_aux_i};
  end

  assign rd_sel = DIW'({head_lane, 5'b00000});

  always_comb begin
    rsp_vld_d   = pop;
    rsp_opc_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_id_d    = '0;
    rsp_aux_d   = '0;
    if (pop) begin
      rsp_id_d  = head_id;
      rsp_aux_d = head_aux;
      rsp_opc_d = head_we ? b_resp_i[1] : r_resp_i[1];
      if (!head_we) rsp_rdata_d = r_data_i[rd_sel +: 32];
    end
  end

`ifdef LINT2AXI_MO_REG_RESP_EN
  logic                 rsp_vld_q, rsp_opc_q;
  logic [31:0]          rsp_rdata_q;
  logic [ID_WIDTH-1:0]  rsp_id_q;
  logic [AUX_WIDTH-1:0] rsp_aux_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld_q   <= 1'b0;
      rsp_opc_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_id_q    <= '0;
      rsp_aux_q   <= '0;
    end else begin
      rsp_vld_q   <= rsp_vld_d;
      rsp_opc_q   <= rsp_opc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_id_q    <= rsp_id_d;
      rsp_aux_q   <= rsp_aux_d;
    end
  end

  assign data_rvalid_o = rsp_vld_q;
  assign data_ropc_o   = rsp_opc_q;
  assign data_rdata_o  = rsp_rdata_q;
  assign data_rID_o    = rsp_id_q;
  assign data_raux_o   = rsp_aux_q;
`else
  assign data_rvalid_o = rsp_vld_d;
  assign data_ropc_o   = rsp_opc_d;
  assign data_rdata_o  = rsp_rdata_d;
  assign data_rID_o    = rsp_id_d;
  assign data_raux_o   = rsp_aux_d;
`endif

  assign outstanding_o = count_q;

  logic unused_axi;
  assign unused_axi = ^{b_id_i, b_user_i, r_id_i, r_last_i, r_user_i, b_resp_i[0], r_resp_i[0]};

endmodule

// File: tb/tb_lint_2_axi_mo.sv
// Bench for lint_2_axi_mo at 128-bit AXI width: directed scenarios plus randomized traffic
// checked against an in-order transaction queue model.
module tb_lint_2_axi_mo;
  localparam int DW = 128, SW = 16, IW = 16, XW = 10, UW = 10, AIW = 5, MO = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_ropc_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0] data_be_i;
  logic [IW-1:0] data_ID_i, data_rID_o;
  logic [XW-1:0] data_aux_i, data_raux_o;
  logic aw_valid_o, aw_ready_i, aw_lock_o, ar_valid_o, ar_ready_i, ar_lock_o;
  logic [31:0] aw_addr_o, ar_addr_o;
  logic [AIW-1:0] aw_id_o, ar_id_o, b_id_i, r_id_i;
  logic [7:0] aw_len_o, ar_len_o;
  logic [2:0] aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
  logic [1:0] aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
  logic [3:0] aw_cache_o, ar_cache_o, aw_region_o, ar_region_o, aw_qos_o, ar_qos_o;
  logic [UW-1:0] aw_user_o, ar_user_o, w_user_o, b_user_i, r_user_i;
  logic w_valid_o, w_ready_i, w_last_o, b_valid_i, b_ready_o, r_valid_i, r_ready_o, r_last_i;
  logic [DW-1:0] w_data_o, r_data_i;
  logic [SW-1:0] w_strb_o;
  logic [2:0] outstanding_o;

  always #5 clk_i = ~clk_i;

  lint_2_axi_mo #(
    .ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW), .AXI_STRB_WIDTH(SW), .ID_WIDTH(IW),
    .AUX_WIDTH(XW), .USER_WIDTH(UW), .AXI_ID_WIDTH(AIW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_aux_i(data_aux_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_ropc_o(data_ropc_o), .data_rID_o(data_rID_o),
    .data_raux_o(data_raux_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_prot_o(aw_prot_o),
    .aw_region_o(aw_region_o), .aw_qos_o(aw_qos_o), .aw_user_o(aw_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o), .w_user_o(w_user_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .b_id_i(b_id_i),
    .b_user_i(b_user_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_prot_o(ar_prot_o),
    .ar_region_o(ar_region_o), .ar_qos_o(ar_qos_o), .ar_user_o(ar_user_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_id_i(r_id_i), .r_last_i(r_last_i), .r_user_i(r_user_i),
    .outstanding_o(outstanding_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [1:0]    lane;
    logic [IW-1:0] id;
    logic [XW-1:0] aux;
  } ent_t;

  ent_t oq[$];
  int   rd_pend = 0, wr_pend = 0;
  bit   aw_done = 0, w_done = 0, granted = 0, b_taken = 0, r_taken = 0;
  bit   no_new = 0;
  logic p_vld = 0, p_opc = 0;
  logic [31:0] p_rd = 0;
  logic [IW-1:0] p_id = 0;
  logic [XW-1:0] p_aux = 0;

  task automatic set_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [IW-1:0] id, input logic [XW-1:0] ax);
    data_req_i = 1'b1; data_we_i = we; data_addr_i = a; data_wdata_i = d;
    data_be_i = be; data_ID_i = id; data_aux_i = ax;
  endtask

  // One clock: check all outputs against the model at negedge, then advance the model.
  task automatic step();
    int n;
    bit part, can, e_aw, e_w, e_ar, e_gnt, hs, hw;
    logic [1:0] ln;
    ent_t h, nw;
    logic c_vld, c_opc;
    logic [31:0] c_rd;
    logic [IW-1:0] c_id;
    logic [XW-1:0] c_aux;
    @(negedge clk_i);
    n    = oq.size();
    ln   = data_addr_i[3:2];
    part = aw_done || w_done;
    can  = data_req_i && (part || n < MO);
    e_aw = can && data_we_i && !aw_done;
    e_w  = can && data_we_i && !w_done;
    e_ar = can && !data_we_i;
    e_gnt = can && (data_we_i ? ((aw_done || aw_ready_i) && (w_done || w_ready_i)) : ar_ready_i);
    chk("aw_valid", aw_valid_o, e_aw);
    chk("w_valid", w_valid_o, e_w);
    chk("ar_valid", ar_valid_o, e_ar);
    chk("gnt", data_gnt_o, e_gnt);
    if (e_aw) chk("aw_addr", aw_addr_o, data_addr_i);
    if (e_ar) chk("ar_addr", ar_addr_o, data_addr_i);
    if (e_w) begin
      chk("w_strb", w_strb_o, 16'(data_be_i) << (4 * ln));
      chk("w_data", w_data_o, {data_wdata_i, data_wdata_i, data_wdata_i, data_wdata_i});
    end
    chk("outstanding", outstanding_o, n);
    hw = (n > 0) && oq[0].we;
    chk("b_ready", b_ready_o, hw);
    chk("r_ready", r_ready_o, (n > 0) && !oq[0].we);
    hs = (n > 0) && (hw ? b_valid_i : r_valid_i);
    c_vld = hs; c_opc = 0; c_rd = 0; c_id = 0; c_aux = 0;
    if (hs) begin
      h = oq[0];
      c_id = h.id; c_aux = h.aux;
      c_opc = hw ? b_resp_i[1] : r_resp_i[1];
      if (!hw) c_rd = 32'(r_data_i >> (32 * h.lane));
    end
`ifdef LINT2AXI_MO_REG_RESP_EN
    chk("rvalid", data_rvalid_o, p_vld);
    chk("rdata", data_rdata_o, p_rd);
    chk("ropc", data_ropc_o, p_opc);
    chk("rID", data_rID_o, p_id);
    chk("raux", data_raux_o, p_aux);
    p_vld = c_vld; p_rd = c_rd; p_opc = c_opc; p_id = c_id; p_aux = c_aux;
`else
    chk("rvalid", data_rvalid_o, c_vld);
    chk("rdata", data_rdata_o, c_rd);
    chk("ropc", data_ropc_o, c_opc);
    chk("rID", data_rID_o, c_id);
    chk("raux", data_raux_o, c_aux);
`endif
    if (hs) begin
      h = oq.pop_front();
      if (hw) begin wr_pend--; b_taken = 1; end
      else    begin rd_pend--; r_taken = 1; end
    end
    if (e_gnt) begin
      nw = '{we: data_we_i, lane: ln, id: data_ID_i, aux: data_aux_i};
      oq.push_back(nw);
      if (data_we_i) wr_pend++; else rd_pend++;
      granted = 1; aw_done = 0; w_done = 0;
    end else begin
      if (e_aw && aw_ready_i) aw_done = 1;
      if (e_w && w_ready_i)   w_done  = 1;
    end
    @(posedge clk_i);
    #1;
    if (granted) begin data_req_i = 1'b0; granted = 0; end
    if (b_taken) begin b_valid_i = 1'b0; b_taken = 0; end
    if (r_taken) begin r_valid_i = 1'b0; r_taken = 0; end
  endtask

  task automatic rnd_drive();
    if (!data_req_i && !no_new && $urandom_range(0, 2) != 0)
      set_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              IW'($urandom), XW'($urandom));
    aw_ready_i = 1'($urandom_range(0, 1));
    w_ready_i  = 1'($urandom_range(0, 1));
    ar_ready_i = 1'($urandom_range(0, 1));
    if (!b_valid_i && wr_pend > 0 && $urandom_range(0, 1) == 1) begin
      b_valid_i = 1'b1; b_resp_i = 2'($urandom_range(0, 3));
    end
    if (!r_valid_i && rd_pend > 0 && $urandom_range(0, 1) == 1) begin
      r_valid_i = 1'b1; r_resp_i = 2'($urandom_range(0, 3));
      r_data_i = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; data_req_i = 1'b0; aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; r_valid_i = 0;
    @(posedge clk_i);
    #1;
    oq.delete(); rd_pend = 0; wr_pend = 0; aw_done = 0; w_done = 0;
    granted = 0; b_taken = 0; r_taken = 0;
    p_vld = 0; p_rd = 0; p_opc = 0; p_id = 0; p_aux = 0;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    chk("rst_r_ready", r_ready_o, 0);
    chk("rst_rvalid", data_rvalid_o, 0);
    chk("rst_rID", data_rID_o, 0);
    chk("rst_aw_valid", aw_valid_o, 0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1; data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_wdata_i = 0;
    data_be_i = 0; data_ID_i = 0; data_aux_i = 0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
    r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 1; r_id_i = 0; b_id_i = 0;
    b_user_i = 0; r_user_i = 0;
    do_reset();
    chk("aw_size", aw_size_o, 3'b010);
    chk("ar_burst", ar_burst_o, 2'b01);
    chk("aw_len", aw_len_o, 0);
    chk("w_last", w_last_o, 1);

    // Write to lane 1 with both channels ready, then OKAY response.
    set_req(1, 32'h1C00_0004, 32'hA5A5_1234, 4'hF, 16'h0011, 10'h011);
    aw_ready_i = 1; w_ready_i = 1; #1;
    chk("t1_gnt", data_gnt_o, 1);
    chk("t1_strb", w_strb_o, 16'h00F0);
    step();
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1; b_resp_i = 2'b00;
    step(); step();

    // Read from lane 3 with SLVERR.
    set_req(0, 32'h0000_000C, 0, 4'hF, 16'h0022, 10'h022);
    ar_ready_i = 1; #1;
    chk("t2_gnt", data_gnt_o, 1);
    step();
    ar_ready_i = 0; r_data_i = {32'hDEADBEEF, 96'h0}; r_resp_i = 2'b10; r_valid_i = 1;
    step(); step();

    // W taken first, AW stalled three cycles.
    set_req(1, 32'h0000_0008, 32'h0BAD_F00D, 4'h3, 16'h0033, 10'h033);
    aw_ready_i = 0; w_ready_i = 1;
    step();
    w_ready_i = 0;
    step(); step(); #1;
    chk("t3_aw_held", aw_valid_o, 1);
    chk("t3_w_done", w_valid_o, 0);
    chk("t3_no_gnt", data_gnt_o, 0);
    aw_ready_i = 1; #1;
    chk("t3_gnt", data_gnt_o, 1);
    step();
    aw_ready_i = 0; b_valid_i = 1; b_resp_i = 2'b11;
    step(); step();

    // Five back-to-back reads with no R: the fifth waits for a pop.
    ar_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 32'h100 + 32'(i * 4), 0, 4'hF, IW'(16'h40 + i), XW'(i));
      step();
    end
    #1;
    chk("t4_full_out", outstanding_o, 4);
    chk("t4_full_arv", ar_valid_o, 0);
    r_data_i = {$urandom, $urandom, $urandom, $urandom}; r_resp_i = 0; r_valid_i = 1; #1;
    chk("t4_pop_no_gnt", data_gnt_o, 0);
    step(); #1;
    chk("t4_gnt_after", data_gnt_o, 1);
    step();
    ar_ready_i = 0;
    for (int i = 0; i < 12; i++) begin
      if (!r_valid_i && rd_pend > 0) begin
        r_valid_i = 1; r_data_i = {$urandom, $urandom, $urandom, $urandom}; r_resp_i = 2'($urandom_range(0, 3));
      end
      step();
    end

    // Read, write, read with B arriving before the first R.
    aw_ready_i = 1; w_ready_i = 1; ar_ready_i = 1;
    set_req(0, 32'h204, 0, 4'hF, 16'h0051, 10'h051); step();
    set_req(1, 32'h208, 32'h1357_9BDF, 4'h5, 16'h0052, 10'h052); step();
    set_req(0, 32'h20C, 0, 4'hF, 16'h0053, 10'h053); step();
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 1; b_resp_i = 2'b10;
    step(); step(); #1;
    chk("t5_b_stall", b_ready_o, 0);
    r_valid_i = 1; r_data_i = {$urandom, $urandom, $urandom, $urandom}; r_resp_i = 0;
    step(); step();
    r_valid_i = 1; r_data_i = {$urandom, $urandom, $urandom, $urandom}; r_resp_i = 2'b10;
    step(); step();

    // Reset with three reads outstanding and the FSM waiting on AW.
    ar_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 32'h300 + 32'(i * 4), 0, 4'hF, IW'(16'h60 + i), XW'(i));
      step();
    end
    ar_ready_i = 0;
    set_req(1, 32'h310, 32'h2468_ACE0, 4'hC, 16'h0070, 10'h070);
    w_ready_i = 1; step(); w_ready_i = 0;
    #1;
    chk("t6_pre_out", outstanding_o, 3);
    do_reset();
    b_valid_i = 1; #1;
    chk("stray_b_ready", b_ready_o, 0);
    b_valid_i = 0;
    set_req(1, 32'h314, 32'h1111_2222, 4'hF, 16'h0071, 10'h071); #1;
    chk("t6_idle_aw", aw_valid_o, 1);
    chk("t6_idle_w", w_valid_o, 1);
    step();
    aw_ready_i = 1; w_ready_i = 1; step();
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1; b_resp_i = 0;
    step(); step();

    // Randomized traffic, then drain.
    for (int i = 0; i < 3000; i++) begin
      rnd_drive();
      step();
    end
    no_new = 1;
    for (int i = 0; i < 300; i++) begin
      rnd_drive();
      step();
    end
    #1;
    chk("drain_outstanding", outstanding_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
